// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C slave emulating a 24Cxx-style EEPROM with an 8-bit auto-incrementing word pointer.
// Ports:
//   clk      system clock, at least 16x the SCL frequency
//   rst      asynchronous active-high reset
//   scl_i    bus SCL level from the pad (input only, never stretched)
//   sda_i    bus SDA level from the pad
//   sda_oe_o 1 pulls SDA low, 0 releases it to the pull-up
//   busy_o   1 from START until STOP or return to idle
module i2c_eeprom_slave #(
    parameter logic [6:0] ADDRESS    = 7'b1010_000,
    parameter int         MEM_DEPTH  = 256,
    parameter logic [7:0] RESET_BYTE = 8'hFF
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    output logic busy_o
);
    localparam int AW = $clog2(MEM_DEPTH);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_IGNORE, S_WADDR, S_WADDR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;
    state_t        r_state;
    logic          r_scl_s1, r_scl_s2, r_scl_d;
    logic          r_sda_s1, r_sda_s2, r_sda_d;
    logic [3:0]    r_cnt;
    logic [7:0]    r_sr;
    logic          r_rw;
    logic          r_nack;
    logic [AW-1:0] r_ptr;
    logic [7:0]    r_mem [MEM_DEPTH];
    logic          r_oe;
    logic          r_busy;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_shift;
    logic [7:0]    w_byte, w_rd;
    logic [AW-1:0] w_ptr_inc;
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;
    assign w_byte     = {r_sr[6:0], r_sda_s2};
    assign w_rd       = r_mem[r_ptr];
    assign w_ptr_inc  = (r_ptr == AW'(MEM_DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    // States that shift master bits in on SCL rise (until 8 bits are held)
    assign w_shift    = (r_state == S_ADDR || r_state == S_WADDR || r_state == S_WDATA) && r_cnt != 4'd8;
    assign sda_oe_o   = r_oe;
    assign busy_o     = r_busy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_rw    <= 1'b0;
            r_nack  <= 1'b0;
            r_ptr   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= RESET_BYTE;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
            if (w_start) begin
                r_state <= S_ADDR;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_oe    <= 1'b0;
            end else if (w_scl_rise) begin
                if (w_shift) begin
                    r_sr  <= w_byte;
                    r_cnt <= r_cnt + 4'd1;
                    // Commit on the 8th rise so a byte cut short by STOP never lands
                    if (r_state == S_WDATA && r_cnt == 4'd7) begin
                        r_mem[r_ptr] <= w_byte;
                        r_ptr        <= w_ptr_inc;
                    end
                end
                if (r_state == S_RACK) r_nack <= r_sda_s2;
            end else if (w_scl_fall) begin
                case (r_state)
                    S_ADDR: if (r_cnt == 4'd8) begin
                        r_rw    <= r_sr[0];
                        r_oe    <= r_sr[7:1] == ADDRESS;
                        r_state <= (r_sr[7:1] == ADDRESS) ? S_ADDR_ACK : S_IGNORE;
                    end
                    S_ADDR_ACK: begin
                        r_cnt   <= '0;
                        r_sr    <= w_rd;
                        // Read: first data bit replaces the ACK on this same fall
                        r_oe    <= r_rw ? ~w_rd[7] : 1'b0;
                        r_state <= r_rw ? S_RDATA : S_WADDR;
                    end
                    S_WADDR: if (r_cnt == 4'd8) begin
                        r_ptr   <= r_sr[AW-1:0];
                        r_oe    <= 1'b1;
                        r_state <= S_WADDR_ACK;
                    end
                    S_WDATA: if (r_cnt == 4'd8) begin
                        r_oe    <= 1'b1;
                        r_state <= S_WDATA_ACK;
                    end
                    S_WADDR_ACK, S_WDATA_ACK: begin
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WDATA;
                    end
                    S_RDATA: if (r_cnt == 4'd7) begin
                        r_oe    <= 1'b0;
                        r_ptr   <= w_ptr_inc;
                        r_state <= S_RACK;
                    end else begin
                        r_sr  <= {r_sr[6:0], 1'b0};
                        r_oe  <= ~r_sr[6];
                        r_cnt <= r_cnt + 4'd1;
                    end
                    S_RACK: begin
                        r_cnt   <= '0;
                        r_sr    <= w_rd;
                        r_oe    <= r_nack ? 1'b0 : ~w_rd[7];
                        r_state <= r_nack ? S_IGNORE : S_RDATA;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bit-banged I2C master with a reference memory model and scoreboard queue.
module tb_i2c_eeprom_slave;
    localparam int Q = 10;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       busy;
    logic       sda_bus;
    logic       mon = 1'b0;
    logic       seen_oe = 1'b0;
    logic [7:0] model [256];
    logic [7:0] exp_q [$];
    logic [7:0] mptr;
    int         n_vec = 0;
    int         n_err = 0;
    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;
    i2c_eeprom_slave dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe_o(sda_oe), .busy_o(busy)
    );
    always @(negedge clk) seen_oe <= mon ? (seen_oe | sda_oe) : 1'b0;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask
    task automatic half();
        repeat (Q) @(negedge clk);
    endtask
    task automatic bus_start();
        sda_m = 1'b1; half();
        scl_m = 1'b1; half();
        sda_m = 1'b0; half();
        scl_m = 1'b0; half();
    endtask
    task automatic bus_stop();
        sda_m = 1'b0; half();
        scl_m = 1'b1; half();
        sda_m = 1'b1; half();
    endtask
    task automatic put_bit(input logic b);
        sda_m = b; half();
        scl_m = 1'b1; half();
        scl_m = 1'b0; half();
    endtask
    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input string tag);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        sda_m = 1'b1;
        exp_q.push_back({7'd0, ack_exp});
        half();
        scl_m = 1'b1;
        repeat (Q / 2) @(negedge clk);
        check(tag, {7'd0, sda_oe}, exp_q.pop_front());
        repeat (Q / 2) @(negedge clk);
        scl_m = 1'b0; half();
    endtask
    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; half();
            scl_m = 1'b1; half();
            d[i] = sda_bus;
            scl_m = 1'b0; half();
        end
        put_bit(nack);
        sda_m = 1'b1;
    endtask
    task automatic read_cur(input int n);
        logic [7:0] d;
        send_byte(8'hA1, 1'b1, "rd_addr_ack");
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model[mptr]);
            read_byte(i == n - 1, d);
            check("rd_data", d, exp_q.pop_front());
            mptr = mptr + 8'd1;
        end
    endtask
    task automatic random_read(input logic [7:0] a, input int n);
        bus_start();
        send_byte(8'hA0, 1'b1, "rr_addr_ack");
        send_byte(a, 1'b1, "rr_word_ack");
        mptr = a;
        bus_start();
        read_cur(n);
        bus_stop();
    endtask
    task automatic do_write(input logic [7:0] a, input int n, input logic [23:0] bytes);
        logic [7:0] b;
        bus_start();
        send_byte(8'hA0, 1'b1, "w_addr_ack");
        send_byte(a, 1'b1, "w_word_ack");
        mptr = a;
        for (int i = 0; i < n; i++) begin
            b = bytes[23 - 8 * i -: 8];
            send_byte(b, 1'b1, "w_data_ack");
            model[mptr] = b;
            mptr = mptr + 8'd1;
        end
        bus_stop();
    endtask
    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 256; i++) model[i] = 8'hFF;
        mptr = 8'h00;
        repeat (4) @(negedge clk);
        check("rst_oe", {7'd0, sda_oe}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        random_read(8'h00, 1);
        do_write(8'h10, 1, 24'h5A0000);
        random_read(8'h10, 1);
        do_write(8'hFE, 3, 24'h112233);
        random_read(8'hFE, 3);
        mon = 1'b1;
        bus_start();
        send_byte(8'hA2, 1'b0, "bad_addr_nack");
        send_byte(8'h10, 1'b0, "bad_word_nack");
        send_byte(8'h77, 1'b0, "bad_data_nack");
        bus_stop();
        check("bad_no_drive", {7'd0, seen_oe}, 8'h00);
        check("bad_busy", {7'd0, busy}, 8'h00);
        mon = 1'b0;
        do_write(8'h11, 2, 24'h3CC300);
        random_read(8'h10, 1);
        bus_start();
        read_cur(1);
        bus_stop();
        bus_start();
        read_cur(1);
        bus_stop();
        bus_start();
        send_byte(8'hA0, 1'b1, "ab_addr_ack");
        send_byte(8'h20, 1'b1, "ab_word_ack");
        for (int i = 0; i < 4; i++) put_bit(1'b0);
        bus_stop();
        check("ab_busy", {7'd0, busy}, 8'h00);
        random_read(8'h20, 1);
        bus_start();
        send_byte(8'hA0, 1'b1, "mr_addr_ack");
        send_byte(8'h10, 1'b1, "mr_word_ack");
        bus_start();
        send_byte(8'hA1, 1'b1, "mr_rd_ack");
        half();
        check("mr_msb_drive", {7'd0, sda_oe}, 8'h01);
        check("mr_busy", {7'd0, busy}, 8'h01);
        #3 rst = 1'b1;
        #1;
        check("mr_rst_oe", {7'd0, sda_oe}, 8'h00);
        check("mr_rst_busy", {7'd0, busy}, 8'h00);
        sda_m = 1'b1;
        scl_m = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 8'hFF;
        mptr = 8'h00;
        repeat (4) @(negedge clk);
        random_read(8'h10, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
